// File: rtl/iso_alu_hs_if.sv
// Operand/result handshake bundle for iso_alu_hs.
// master = operand source and result sink side, slave = the ALU itself.
interface iso_alu_hs_if #(
   parameter int WIDTH = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [3:0]           sel;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out;
   logic                 div_by_zero;

   modport master (
      output in_valid, a, b, sel, out_ready,
      input  in_ready, out_valid, out, div_by_zero
   );

   modport slave (
      input  in_valid, a, b, sel, out_ready,
      output in_ready, out_valid, out, div_by_zero
   );
endinterface

// File: rtl/iso_alu_hs.sv
// iso_alu_hs: priority-select MUL/ADD/DIV/SUB ALU on WIDTH-bit unsigned operands
// with valid/ready handshakes on both sides. MUL/ADD/SUB/NOP and divide-by-zero
// answer one cycle after accept; divide runs a restoring divider, one quotient bit
// per cycle. Build option ISO_OPERAND_EN gives each arithmetic unit its own operand
// registers so that units not in use see constant zero operands.
module iso_alu_hs #(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,     // synchronous, active low
   iso_alu_hs_if.slave   bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_RESP} state_e;
   typedef enum logic [2:0] {OP_NOP, OP_MUL, OP_ADD, OP_DIV, OP_SUB} op_e;

   state_e            state_q;
   op_e               op_q, op_d;
   logic              out_valid_q;
   logic              dbz_q;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic [WIDTH-1:0]  quo_q, quo_d;
   logic [CW-1:0]     cnt_q;
   logic              accept;

   // Operands as seen by each arithmetic unit
   logic [WIDTH-1:0]  mul_a, mul_b, add_a, add_b, div_a, div_b, sub_a, sub_b;

   assign bus.in_ready = rst && ((state_q == ST_IDLE) ||
                                 (state_q == ST_RESP && bus.out_ready));
   assign accept       = bus.in_valid && bus.in_ready;

   // Priority decode of the select lines; highest set bit wins
   always_comb begin
      op_d = OP_NOP;
      casez (bus.sel)
         4'b1???: op_d = OP_MUL;
         4'b01??: op_d = OP_ADD;
         4'b001?: op_d = OP_DIV;
         4'b0001: op_d = OP_SUB;
         default: op_d = OP_NOP;
      endcase
   end

`ifdef ISO_OPERAND_EN
   logic [WIDTH-1:0] a_mul_q, b_mul_q, a_add_q, b_add_q;
   logic [WIDTH-1:0] a_div_q, b_div_q, a_sub_q, b_sub_q;

   // Per-unit operand registers: only the decoded unit gets real operands
   always_ff @(posedge clk) begin
      // NOTE: every register is cleared on reset here; these are a handful of
      // flops, not a memory array, so a full reset is cheap and makes the
      // post-reset state fully defined.
      if (!rst) begin
         a_mul_q <= '0;  b_mul_q <= '0;
         a_add_q <= '0;  b_add_q <= '0;
         a_div_q <= '0;  b_div_q <= '0;
         a_sub_q <= '0;  b_sub_q <= '0;
      end else if (accept) begin
         a_mul_q <= (op_d == OP_MUL) ? bus.a : '0;
         b_mul_q <= (op_d == OP_MUL) ? bus.b : '0;
         a_add_q <= (op_d == OP_ADD) ? bus.a : '0;
         b_add_q <= (op_d == OP_ADD) ? bus.b : '0;
         a_div_q <= (op_d == OP_DIV) ? bus.a : '0;
         b_div_q <= (op_d == OP_DIV) ? bus.b : '0;
         a_sub_q <= (op_d == OP_SUB) ? bus.a : '0;
         b_sub_q <= (op_d == OP_SUB) ? bus.b : '0;
      end
   end

   assign mul_a = a_mul_q;  assign mul_b = b_mul_q;
   assign add_a = a_add_q;  assign add_b = b_add_q;
   assign div_a = a_div_q;  assign div_b = b_div_q;
   assign sub_a = a_sub_q;  assign sub_b = b_sub_q;
`else
   logic [WIDTH-1:0] a_q, b_q;

   // Single shared operand pair, captured on every accept
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q <= '0;
         b_q <= '0;
      end else if (accept) begin
         a_q <= bus.a;
         b_q <= bus.b;
      end
   end

   assign mul_a = a_q;  assign mul_b = b_q;
   assign add_a = a_q;  assign add_b = b_q;
   assign div_a = a_q;  assign div_b = b_q;
   assign sub_a = a_q;  assign sub_b = b_q;
`endif

   // One restoring-division step: bring down the next dividend bit, try a subtract
   always_comb begin
      logic [WIDTH-1:0] dvd_sh;
      logic [WIDTH:0]   shifted;
      logic [WIDTH:0]   trial;
      dvd_sh  = div_a << cnt_q;
      shifted = {rem_q, dvd_sh[WIDTH-1]};
      trial   = shifted - {1'b0, div_b};
      rem_d   = shifted[WIDTH-1:0];
      quo_d   = {quo_q[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH]) begin
         rem_d = trial[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
   end

   // Control FSM plus divider state; out_valid/div_by_zero are registered here
   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NOP;
         out_valid_q <= 1'b0;
         dbz_q       <= 1'b0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
      end else if (accept) begin
         op_q  <= op_d;
         rem_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
         if (op_d == OP_DIV && bus.b != '0) begin
            state_q     <= ST_DIV;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
         end else begin
            state_q     <= ST_RESP;
            out_valid_q <= 1'b1;
            dbz_q       <= (op_d == OP_DIV);
         end
      end else begin
         case (state_q)
            ST_DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  state_q     <= ST_RESP;
                  out_valid_q <= 1'b1;
               end
            end
            ST_RESP: begin
               if (bus.out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  dbz_q       <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Result select; driven only from registers, so it is stable throughout RESP
   always_comb begin
      logic [2*WIDTH-1:0] result;
      result = '0;
      if (state_q == ST_RESP) begin
         case (op_q)
            OP_MUL: result = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
            OP_ADD: result = {{WIDTH{1'b0}}, add_a} + {{WIDTH{1'b0}}, add_b};
            OP_DIV: result = dbz_q ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                   : {{WIDTH{1'b0}}, quo_q};
            // Both operands fit in WIDTH bits, so a 2*WIDTH subtract is exactly
            // the sign-extended difference.
            OP_SUB: result = {{WIDTH{1'b0}}, sub_a} - {{WIDTH{1'b0}}, sub_b};
            default: result = '0;
         endcase
      end
      bus.out = result;
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_iso_alu_hs.sv
// Directed bench for iso_alu_hs at WIDTH=4. Inputs change 1 ns after the rising
// edge; outputs are sampled shortly after that, well away from the edge.
module tb_iso_alu_hs;

   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   iso_alu_hs_if #(.WIDTH(WIDTH)) bus ();

   iso_alu_hs #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one operation for one cycle; it must be accepted immediately
   task automatic issue(input logic [3:0] s, input logic [3:0] av, input logic [3:0] bv);
      bus.in_valid = 1'b1;
      bus.sel      = s;
      bus.a        = av;
      bus.b        = bv;
      #1;
      check("in_ready_at_issue", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      #1;
   endtask

   task automatic expect_result(input string tag, input logic [7:0] val, input logic dbz);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_out"},   32'(bus.out),       32'(val));
      check({tag, "_dbz"},   32'(bus.div_by_zero), 32'(dbz));
   endtask

   initial begin
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      bus.sel       = '0;

      // Reset state
      step();
      step();
      check("rst_in_ready",  32'(bus.in_ready),   32'd0);
      check("rst_out_valid", 32'(bus.out_valid),  32'd0);
      check("rst_out",       32'(bus.out),        32'd0);
      check("rst_dbz",       32'(bus.div_by_zero), 32'd0);
      rst = 1'b1;
      #1;
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);

      // Single-cycle ops, back to back (out_ready held high)
      issue(4'b1000, 4'd15, 4'd15);  expect_result("mul_15x15", 8'd225, 1'b0);
      issue(4'b0001, 4'd3,  4'd5);   expect_result("sub_3m5",   8'hFE,  1'b0);
      issue(4'b0100, 4'd15, 4'd1);   expect_result("add_15p1",  8'h10,  1'b0);
`ifdef ISO_OPERAND_EN
      check("iso_a_mul", 32'(dut.a_mul_q), 32'd0);
      check("iso_b_mul", 32'(dut.b_mul_q), 32'd0);
      check("iso_a_div", 32'(dut.a_div_q), 32'd0);
      check("iso_b_div", 32'(dut.b_div_q), 32'd0);
      check("iso_a_sub", 32'(dut.a_sub_q), 32'd0);
      check("iso_b_sub", 32'(dut.b_sub_q), 32'd0);
      check("iso_a_add", 32'(dut.a_add_q), 32'd15);
`endif
      issue(4'b0000, 4'd9,  4'd9);   expect_result("nop",       8'h00,  1'b0);
      issue(4'b1111, 4'd3,  4'd7);   expect_result("sel1111",   8'h15,  1'b0);

      // Divide 13/4: busy for WIDTH cycles, extra offers ignored
      issue(4'b0010, 4'd13, 4'd4);
      for (int k = 1; k <= WIDTH; k++) begin
         check("div_busy_in_ready",  32'(bus.in_ready),  32'd0);
         check("div_busy_out_valid", 32'(bus.out_valid), 32'd0);
         bus.in_valid = 1'b1;
         bus.sel      = 4'b1000;
         bus.a        = 4'd2;
         bus.b        = 4'd2;
         step();
      end
      bus.in_valid = 1'b0;
      #1;
      expect_result("div_13d4", 8'h03, 1'b0);
      step();
      check("div_no_extra", 32'(bus.out_valid), 32'd0);

      // Divider boundary values
      issue(4'b0010, 4'd15, 4'd1);
      for (int k = 1; k < WIDTH; k++) step();
      #1;
      check("div_15d1_pending", 32'(bus.out_valid), 32'd0);
      step();
      expect_result("div_15d1", 8'h0F, 1'b0);
      step();
      issue(4'b0010, 4'd7, 4'd9);
      for (int k = 1; k <= WIDTH; k++) step();
      expect_result("div_7d9", 8'h00, 1'b0);
      step();

      // Divide by zero, then hold the result with out_ready low
      issue(4'b0011, 4'd9, 4'd0);
      expect_result("dbz", 8'h0F, 1'b1);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.sel      = 4'b0100;
         bus.a        = 4'd1;
         bus.b        = 4'd1;
         #1;
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         step();
         expect_result("hold", 8'h0F, 1'b1);
      end
      // Release the sink and offer a new op in the same cycle
      bus.out_ready = 1'b1;
      issue(4'b0100, 4'd2, 4'd3);
      expect_result("after_hold_add", 8'h05, 1'b0);

      // Reset in the middle of a divide
      issue(4'b0010, 4'd13, 4'd4);
      step();
      rst = 1'b0;
      step();
      check("midrst_out_valid", 32'(bus.out_valid),   32'd0);
      check("midrst_out",       32'(bus.out),         32'd0);
      check("midrst_dbz",       32'(bus.div_by_zero), 32'd0);
      check("midrst_in_ready",  32'(bus.in_ready),    32'd0);
      rst = 1'b1;
      for (int k = 0; k < WIDTH + 2; k++) begin
         step();
         check("midrst_no_stale", 32'(bus.out_valid), 32'd0);
      end
      #1;
      check("midrst_idle_ready", 32'(bus.in_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
